// File: rtl/sharemem_req_ctrl_if.sv
// Request / arbiter / response bundle for the shared-memory request controller.
// The slave view is the controller; the master view is its environment (LSU, arbiter, consumer).
interface sharemem_req_ctrl_if #(
  parameter int NLANES = 16,
  parameter int TAGW   = 8
);
  localparam int CNTW = $clog2(NLANES) + 1;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_is_write_i;
  logic [NLANES-1:0] req_activemask_i;
  logic [TAGW-1:0]   req_tag_i;

  logic              arb_enable_o;
  logic              arb_is_write_o;
  logic [NLANES-1:0] arb_activemask_o;
  logic              arb_bankconflict_i;
  logic [NLANES-1:0] arb_active_lane_i;

  logic              resp_valid_o;
  logic              resp_ready_i;
  logic              resp_is_write_o;
  logic [TAGW-1:0]   resp_tag_o;
  logic [NLANES-1:0] resp_lanemask_o;
  logic [CNTW-1:0]   resp_replays_o;
  logic              resp_mismatch_o;

  modport slave (
    input  req_valid_i, req_is_write_i, req_activemask_i, req_tag_i,
    input  arb_bankconflict_i, arb_active_lane_i, resp_ready_i,
    output req_ready_o, arb_enable_o, arb_is_write_o, arb_activemask_o,
    output resp_valid_o, resp_is_write_o, resp_tag_o, resp_lanemask_o,
    output resp_replays_o, resp_mismatch_o
  );

  modport master (
    output req_valid_i, req_is_write_i, req_activemask_i, req_tag_i,
    output arb_bankconflict_i, arb_active_lane_i, resp_ready_i,
    input  req_ready_o, arb_enable_o, arb_is_write_o, arb_activemask_o,
    input  resp_valid_o, resp_is_write_o, resp_tag_o, resp_lanemask_o,
    input  resp_replays_o, resp_mismatch_o
  );
endinterface

// File: rtl/sharemem_req_ctrl.sv
// Shared-memory request controller: accepts one LSU request, follows bank-conflict replays, returns one response.
// Optional performance counters are built only when SHAREMEM_PERF_CNT_EN is defined.
module sharemem_req_ctrl #(
  parameter int NLANES = 16,
  parameter int TAGW   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  sharemem_req_ctrl_if.slave  bus,
  output logic                busy_o,
  output logic [31:0]         perf_req_cnt_o,
  output logic [31:0]         perf_conf_cyc_o
);
  localparam int CNTW = $clog2(NLANES) + 1;
  localparam logic [CNTW-1:0] REPLAY_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPLAY = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              is_write_q, is_write_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [NLANES-1:0] amask_q, amask_d;
  logic [NLANES-1:0] acc_q, acc_d;
  logic [CNTW-1:0]   replays_q, replays_d;
  logic              req_ready;
  logic              accept;

  // Ready is masked by reset so nothing is handed to the arbiter while rst_n is low.
  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = bus.req_valid_i && req_ready;

  assign bus.req_ready_o      = req_ready;
  assign bus.arb_enable_o     = accept;
  assign bus.arb_is_write_o   = (state_q == IDLE) ? bus.req_is_write_i   : is_write_q;
  assign bus.arb_activemask_o = (state_q == IDLE) ? bus.req_activemask_i : amask_q;

  assign bus.resp_valid_o     = (state_q == RESP);
  assign bus.resp_is_write_o  = is_write_q;
  assign bus.resp_tag_o       = tag_q;
  assign bus.resp_lanemask_o  = acc_q;
  assign bus.resp_replays_o   = replays_q;
  assign bus.resp_mismatch_o  = (state_q == RESP) && (acc_q != amask_q);
  assign busy_o               = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    tag_d      = tag_q;
    amask_d    = amask_q;
    acc_d      = acc_q;
    replays_d  = replays_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          is_write_d = bus.req_is_write_i;
          tag_d      = bus.req_tag_i;
          amask_d    = bus.req_activemask_i;
          acc_d      = bus.arb_active_lane_i;
          replays_d  = '0;
          state_d    = bus.arb_bankconflict_i ? REPLAY : RESP;
        end
      end
      REPLAY: begin
        acc_d = acc_q | bus.arb_active_lane_i;
        if (replays_q != REPLAY_MAX) begin
          replays_d = replays_q + CNTW'(1);
        end
        if (!bus.arb_bankconflict_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      tag_q      <= '0;
      amask_q    <= '0;
      acc_q      <= '0;
      replays_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      tag_q      <= tag_d;
      amask_q    <= amask_d;
      acc_q      <= acc_d;
      replays_q  <= replays_d;
    end
  end

`ifdef SHAREMEM_PERF_CNT_EN
  logic [31:0] perf_req_q, perf_req_d;
  logic [31:0] perf_conf_q, perf_conf_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    perf_req_d  = perf_req_q;
    perf_conf_d = perf_conf_q;
    if (accept && (perf_req_q != 32'hFFFF_FFFF)) begin
      perf_req_d = perf_req_q + 32'd1;
    end
    if ((state_q == REPLAY) && (perf_conf_q != 32'hFFFF_FFFF)) begin
      perf_conf_d = perf_conf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_req_q  <= '0;
      perf_conf_q <= '0;
    end else begin
      perf_req_q  <= perf_req_d;
      perf_conf_q <= perf_conf_d;
    end
  end

  assign perf_req_cnt_o  = perf_req_q;
  assign perf_conf_cyc_o = perf_conf_q;
`else
  assign perf_req_cnt_o  = 32'd0;
  assign perf_conf_cyc_o = 32'd0;
`endif

endmodule

// File: doc/sharemem_req_ctrl.md
SHAREMEM_REQ_CTRL -- requirements
Module: sharemem_req_ctrl

Interface
REQ-001 Parameters SHALL be: NLANES, default 16, lanes per request; TAGW, default 8, request tag width; CNTW = $clog2(NLANES)+1, derived, replay-count width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- req_valid_i  in  1  request from the LSU is present
- req_ready_o  out  1  controller accepts a request
- req_is_write_i  in  1  request is a store
- req_activemask_i  in  NLANES  active lanes
- req_tag_i  in  TAGW  request identifier
- arb_enable_o  out  1  enable to the bank-conflict arbiter
- arb_is_write_o  out  1  write flag to the arbiter
- arb_activemask_o  out  NLANES  activemask to the arbiter
- arb_bankconflict_i  in  1  arbiter needs a further replay cycle
- arb_active_lane_i  in  NLANES  lanes the arbiter serviced this cycle
- resp_valid_o  out  1  response is valid
- resp_ready_i  in  1  consumer accepts the response
- resp_is_write_o  out  1  latched write flag
- resp_tag_o  out  TAGW  latched tag
- resp_lanemask_o  out  NLANES  OR of all serviced lanes
- resp_replays_o  out  CNTW  number of extra cycles spent on conflicts
- resp_mismatch_o  out  1  serviced mask differs from activemask
- busy_o  out  1  controller state is not IDLE
- perf_req_cnt_o  out  32  accepted requests
- perf_conf_cyc_o  out  32  conflict replay cycles

Function
REQ-003 The state machine SHALL have three states: IDLE, REPLAY and RESP.
REQ-004 req_ready_o SHALL be 1 only in IDLE.
REQ-005 A request SHALL be accepted on a cycle where req_valid_i and req_ready_o are both 1.
REQ-006 On the accept cycle the controller SHALL drive the request to the arbiter combinationally:
- arb_enable_o = 1
- arb_is_write_o = req_is_write_i
- arb_activemask_o = req_activemask_i
REQ-007 On accept, the controller SHALL latch is_write, tag and activemask, and load the accumulator acc = arb_active_lane_i.
REQ-008 Transitions out of IDLE on accept:
- arb_bankconflict_i = 0: next state RESP, replay count = 0.
- arb_bankconflict_i = 1: next state REPLAY, replay count = 0.
REQ-009 In REPLAY, each cycle:
- arb_enable_o = 0.
- arb_is_write_o and arb_activemask_o hold their latched values (the arbiter replays from its own registers).
- acc |= arb_active_lane_i.
- The replay count increments, saturating at 2^CNTW-1.
REQ-010 REPLAY SHALL go to RESP on the first REPLAY cycle with arb_bankconflict_i = 0; that cycle's lanes are included in acc.
REQ-011 In RESP:
- resp_valid_o = 1 and all resp_* outputs are stable.
- The controller SHALL go to IDLE on the cycle where resp_ready_i = 1.
- While resp_ready_i = 0 the controller SHALL hold RESP and keep every resp_* output unchanged (no drop, no duplication).
REQ-012 resp_mismatch_o SHALL equal (acc != latched activemask) and SHALL be valid only while resp_valid_o = 1.
REQ-013 Latency with no conflict: accept in cycle N gives resp_valid_o = 1 in cycle N+1.
REQ-014 Latency with k replay cycles: accept in cycle N gives resp_valid_o = 1 in cycle N+k+1.
REQ-015 Minimum spacing between two accepts SHALL be 2 cycles, because the RESP handshake returns to IDLE before the next accept.
REQ-016 A request with activemask = 0 SHALL complete through the no-conflict path with resp_lanemask_o = 0 and resp_mismatch_o = 0.
REQ-017 arb_bankconflict_i and arb_active_lane_i SHALL be ignored outside the accept cycle and REPLAY.
REQ-018 arb_enable_o SHALL be 0 in IDLE when req_valid_i = 0, and 0 in RESP.

Reset
REQ-019 With rst_n = 0 at a rising edge, the next state SHALL be IDLE regardless of the current state, including mid-REPLAY and mid-RESP.
REQ-020 After reset:
- Registered outputs (resp_valid_o, resp_tag_o, resp_is_write_o, resp_lanemask_o, resp_replays_o, resp_mismatch_o, busy_o) are 0.
- Both perf counters are 0.
- The accumulator and all latches are 0.
REQ-021 While rst_n = 0, req_ready_o and arb_enable_o SHALL be 0.

Configuration
REQ-022 The macro SHAREMEM_PERF_CNT_EN SHALL control the performance counters.
REQ-023 With SHAREMEM_PERF_CNT_EN defined:
- perf_req_cnt_o increments on each accept.
- perf_conf_cyc_o increments on each REPLAY cycle.
- Both saturate at 32'hFFFFFFFF.
REQ-024 With SHAREMEM_PERF_CNT_EN undefined:
- Both perf outputs are constant 0 and no counter flops exist.
- Every port remains present.

Verification
REQ-025 Scenario, no conflict: accept activemask=16'hFFFF, tag=8'h5A, arbiter returns conflict=0 and lanes=FFFF. Required: resp_valid_o in the next cycle with lanemask=FFFF, replays=0, mismatch=0, tag=5A.
REQ-026 Scenario, three-way conflict: arbiter returns lanes 0001 with conflict=1, then 0002 with conflict=1, then 0004 with conflict=0; activemask=0007. Required: resp at N+3, lanemask=0007, replays=2, perf_conf_cyc_o +2 when the macro is defined.
REQ-027 Scenario, backpressure: resp_ready_i held 0 for 5 cycles. Required: resp outputs stable, req_ready_o=0 throughout, and exactly one response handshake.
REQ-028 Scenario, reset mid-REPLAY: rst_n=0 for one edge. Required: IDLE next cycle, resp_valid_o=0, busy_o=0, perf counters 0.
REQ-029 Scenario, arbiter drops a lane: activemask=00FF and the serviced union is 007F. Required: resp_mismatch_o=1 and lanemask=007F.
REQ-030 Scenario, back-to-back traffic with resp_ready_i tied 1: required accept every 2 cycles, and with the macro undefined both perf outputs stay 0.
